// File: rtl/lamp_fpu_sqrt_issue.sv
// lamp_fpu_sqrt_issue
// -------------------
// Request front-end for the bfloat16 square-root unit. A packed operand is
// accepted over a valid/ready handshake, unpacked and classified at capture,
// and a one-cycle doSqrt pulse starts the sqrt stage. The operand fields stay
// frozen until the next accept, because the sqrt stage samples them
// combinationally when it produces its result. The packed result is returned
// over a second valid/ready handshake. Only one operation is in flight.
//
// Optional feature macro: LAMP_SQRT_TIMEOUT_EN
//   When defined, a watchdog counts WAIT cycles. After TIMEOUT_CYCLES WAIT
//   cycles with no sqrt_valid_i, the unit responds with qNaN (16'h7FC0) and
//   rsp_err_o = 1. When undefined, WAIT has no limit and rsp_err_o is 0.
//
// Parameters:
//   TIMEOUT_CYCLES  watchdog limit in WAIT cycles (2..255, timeout build only)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake
//   req_op_i[15:0]           packed operand {s, e[7:0], f[6:0]}
//   req_inv_i                1 = 1/sqrt(x), 0 = sqrt(x)
//   doSqrt_o                 one-cycle start pulse to the sqrt stage
//   invSqrt_o                registered req_inv_i
//   signum_op_o              operand sign
//   extExp_op_o[7:0]         extended exponent (denormals read as 1)
//   extMant_op_o[7:0]        extended mantissa {hidden, f}
//   isInf/isZero/isSNAN/isQNAN_op_o  operand class flags
//   sqrt_valid_i             sqrt stage result valid
//   sqrt_s_i, sqrt_e_i[7:0], sqrt_f_i[6:0]  sqrt stage result fields
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_res_o[15:0]          packed result
//   rsp_err_o                response produced by the watchdog

module lamp_fpu_sqrt_issue #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] req_op_i,
    input  logic        req_inv_i,
    output logic        doSqrt_o,
    output logic        invSqrt_o,
    output logic        signum_op_o,
    output logic [7:0]  extExp_op_o,
    output logic [7:0]  extMant_op_o,
    output logic        isInf_op_o,
    output logic        isZero_op_o,
    output logic        isSNAN_op_o,
    output logic        isQNAN_op_o,
    input  logic        sqrt_valid_i,
    input  logic        sqrt_s_i,
    input  logic [7:0]  sqrt_e_i,
    input  logic [6:0]  sqrt_f_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_res_o,
    output logic        rsp_err_o
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic       w_accept;
    logic       w_sqrt_done;
    logic       w_timeout;

    logic [7:0] w_e;
    logic [6:0] w_f;

    logic       r_inv;
    logic       r_signum;
    logic [7:0] r_ext_exp;
    logic [7:0] r_ext_mant;
    logic       r_is_inf;
    logic       r_is_zero;
    logic       r_is_snan;
    logic       r_is_qnan;
    logic [15:0] r_rsp_res;

    assign w_e = req_op_i[14:7];
    assign w_f = req_op_i[6:0];

    assign w_accept    = (r_state == S_IDLE) && req_valid_i;
    // Only WAIT listens to the sqrt stage; stray, early or post-reset pulses
    // in any other state are dropped.
    assign w_sqrt_done = (r_state == S_WAIT) && sqrt_valid_i;

`ifdef LAMP_SQRT_TIMEOUT_EN
    localparam logic [7:0] LP_WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wd_cnt;
    logic       r_rsp_err;

    // The counter holds the number of WAIT cycles already completed, so the
    // limit is hit during the TIMEOUT_CYCLES-th WAIT cycle. A real result in
    // that same cycle takes priority.
    assign w_timeout = (r_state == S_WAIT) && !sqrt_valid_i && (r_wd_cnt == LP_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= 8'd0;
        end else if (r_state == S_ISSUE) begin
            r_wd_cnt <= 8'd0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (w_sqrt_done) begin
            r_rsp_err <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_err <= 1'b1;
        end
    end

    assign rsp_err_o = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_sqrt_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: all handshake outputs come straight from the state
    // register, so req_ready_o has no combinational path from rsp_ready_i.
    always_comb begin
        req_ready_o = 1'b0;
        doSqrt_o    = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            S_IDLE:  req_ready_o = 1'b1;
            S_ISSUE: doSqrt_o    = 1'b1;
            S_RESP:  rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and classification; held until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv      <= 1'b0;
            r_signum   <= 1'b0;
            r_ext_exp  <= 8'd0;
            r_ext_mant <= 8'd0;
            r_is_inf   <= 1'b0;
            r_is_zero  <= 1'b0;
            r_is_snan  <= 1'b0;
            r_is_qnan  <= 1'b0;
        end else if (w_accept) begin
            r_inv      <= req_inv_i;
            r_signum   <= req_op_i[15];
            // Denormals use the minimum normal exponent with no hidden bit.
            r_ext_exp  <= (w_e == 8'd0) ? 8'd1 : w_e;
            r_ext_mant <= {(w_e != 8'd0), w_f};
            r_is_inf   <= (w_e == 8'hFF) && (w_f == 7'd0);
            r_is_zero  <= (w_e == 8'd0) && (w_f == 7'd0);
            r_is_snan  <= (w_e == 8'hFF) && (w_f != 7'd0) && !w_f[6];
            r_is_qnan  <= (w_e == 8'hFF) && w_f[6];
        end
    end

    // Response capture; held stable through RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_res <= 16'd0;
        end else if (w_sqrt_done) begin
            r_rsp_res <= {sqrt_s_i, sqrt_e_i, sqrt_f_i};
        end else if (w_timeout) begin
            r_rsp_res <= 16'h7FC0;
        end
    end

    assign invSqrt_o    = r_inv;
    assign signum_op_o  = r_signum;
    assign extExp_op_o  = r_ext_exp;
    assign extMant_op_o = r_ext_mant;
    assign isInf_op_o   = r_is_inf;
    assign isZero_op_o  = r_is_zero;
    assign isSNAN_op_o  = r_is_snan;
    assign isQNAN_op_o  = r_is_qnan;
    assign rsp_res_o    = r_rsp_res;

endmodule
